// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte stream and writes
// 16-bit words into instruction memory, holding the core in reset until a good load.
module imem_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          ADDR_STEP = 4,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [15:0] imem_addr,
    output logic [15:0] imem_wd,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] word_cnt
);
    localparam logic [15:0] STEP16 = 16'(ADDR_STEP);
    localparam logic [15:0] MAXW16 = 16'(MAX_WORDS);

    typedef enum logic [3:0] {
        IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHECK, DONE, ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d, idx_q, idx_d, wcnt_q, wcnt_d;
    logic [15:0] addr_q, addr_d, wd_q, wd_d;
    logic [7:0]  sum_q, sum_d, lo_q, lo_d;
    logic        rdy_q, rdy_d, we_q, we_d, cpu_rst_q, cpu_rst_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic        xfer;

    assign xfer = in_valid && rdy_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        wcnt_d    = wcnt_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
        sum_d     = sum_q;
        lo_d      = lo_q;
        cpu_rst_d = cpu_rst_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        case (state_q)
            IDLE, DONE, ERROR: if (start) begin
                state_d   = LEN_LO;
                sum_d     = 8'h00;
                idx_d     = 16'h0000;
                wcnt_d    = 16'h0000;
                done_d    = 1'b0;
                err_d     = 1'b0;
                cpu_rst_d = 1'b1;
                busy_d    = 1'b1;
            end
            LEN_LO: if (xfer) begin
                len_d   = {len_q[15:8], in_data};
                sum_d   = sum_q + in_data;
                state_d = LEN_HI;
            end
            LEN_HI: if (xfer) begin
                len_d = {in_data, len_q[7:0]};
                sum_d = sum_q + in_data;
                if ({in_data, len_q[7:0]} > MAXW16) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else if ({in_data, len_q[7:0]} == 16'h0000) begin
                    state_d = CHECK;
                end else begin
                    state_d = DATA_LO;
                end
            end
            DATA_LO: if (xfer) begin
                lo_d    = in_data;
                sum_d   = sum_q + in_data;
                state_d = DATA_HI;
            end
            DATA_HI: if (xfer) begin
                sum_d   = sum_q + in_data;
                wd_d    = {in_data, lo_q};
                addr_d  = BASE_ADDR + idx_q * STEP16;
                state_d = WRITE;
            end
            WRITE: begin
                idx_d   = idx_q + 16'd1;
                wcnt_d  = wcnt_q + 16'd1;
                state_d = (idx_q + 16'd1 == len_q) ? CHECK : DATA_LO;
            end
            CHECK: if (xfer) begin
                busy_d = 1'b0;
                if (in_data == sum_q) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    cpu_rst_d = 1'b0;
                end else begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Strobes are registered, so derive them from the state being entered.
        we_d  = (state_d == WRITE);
        rdy_d = (state_d inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            wcnt_q    <= '0;
            addr_q    <= '0;
            wd_q      <= '0;
            sum_q     <= '0;
            lo_q      <= '0;
            rdy_q     <= 1'b0;
            we_q      <= 1'b0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            wcnt_q    <= wcnt_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
            sum_q     <= sum_d;
            lo_q      <= lo_d;
            rdy_q     <= rdy_d;
            we_q      <= we_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign in_ready  = rdy_q;
    assign imem_we   = we_q;
    assign imem_addr = addr_q;
    assign imem_wd   = wd_q;
    assign cpu_rst   = cpu_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = err_q;
    assign word_cnt  = wcnt_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized loads against a stream-level model of the loader.
module tb_imem_loader;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, imem_we, cpu_rst, busy, done, error;
    logic [15:0] imem_addr, imem_wd, word_cnt;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] wq[$];
    int          rdy_bad = 0;

    imem_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    // Record every write seen; in_ready must be low during any write cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wq.push_back({imem_addr, imem_wd});
            if (in_ready !== 1'b0) rdy_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 0);
        chk({tag, "_imem_we"}, {31'd0, imem_we}, 0);
        chk({tag, "_imem_addr"}, {16'd0, imem_addr}, 0);
        chk({tag, "_imem_wd"}, {16'd0, imem_wd}, 0);
        chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 1);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_done"}, {31'd0, done}, 0);
        chk({tag, "_error"}, {31'd0, error}, 0);
        chk({tag, "_word_cnt"}, {16'd0, word_cnt}, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            n_chk++;
            n_fail++;
            $error("FAIL ready_timeout: observed in_ready=%b expected 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    function automatic bq_t mk_stream(input int len, input bit corrupt);
        bq_t s;
        logic [7:0] sum = 8'h00;
        s.push_back(8'(len));
        s.push_back(8'(len >> 8));
        for (int i = 0; i < 2 * len; i++) s.push_back(8'($urandom));
        foreach (s[i]) sum = sum + s[i];
        s.push_back(corrupt ? sum + 8'd1 : sum);
        return s;
    endfunction

    // Model: length header, little-endian words, mod-256 checksum over everything before it.
    task automatic run_load(input string tag, input bq_t bs, input int gap_max, input bit mid_start);
        int         len, nsend, nw;
        bit         over, ok;
        logic [7:0] sum;
        logic [15:0] ea, ed;
        len   = int'({bs[1], bs[0]});
        over  = (len > 64);
        nsend = over ? 2 : bs.size();
        nw    = over ? 0 : len;
        sum   = 8'h00;
        if (!over) for (int i = 0; i < 2 + 2 * len; i++) sum = sum + bs[i];
        ok = !over && (sum == bs[2 + 2 * len]);
        wq.delete();
        rdy_bad = 0;
        pulse_start();
        for (int i = 0; i < nsend; i++) begin
            repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            if (mid_start && i == 3) pulse_start();
            send_byte(bs[i]);
        end
        repeat (4) @(negedge clk);
        chk({tag, "_done"}, {31'd0, done}, {31'd0, ok});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, !ok});
        chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, !ok});
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 0);
        chk({tag, "_word_cnt"}, {16'd0, word_cnt}, 32'(nw));
        chk({tag, "_nwrites"}, 32'(wq.size()), 32'(nw));
        chk({tag, "_rdy_in_write"}, 32'(rdy_bad), 0);
        for (int i = 0; i < nw && i < wq.size(); i++) begin
            ea = 16'(i * 4);
            ed = {bs[3 + 2 * i], bs[2 + 2 * i]};
            chk($sformatf("%s_write%0d", tag, i), wq[i], {ea, ed});
        end
    endtask

    initial begin
        bq_t good, bad;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("idle");

        good = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hC0};
        bad  = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hC1};
        run_load("good", good, 0, 0);
        run_load("empty", '{8'h00, 8'h00, 8'h00}, 0, 0);
        run_load("oversize", '{8'h41, 8'h00}, 0, 0);
        run_load("badsum", bad, 0, 0);
        run_load("backpressure", good, 5, 1);

        // Reset in the cycle right after the fourth byte (the first write).
        wq.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(good[i]);
        #1 rst = 1'b1;
        #1 check_reset_vals("midreset");
        @(negedge clk);
        rst = 1'b0;
        run_load("after_reset", good, 0, 0);

        run_load("max64", mk_stream(64, 0), 0, 0);
        run_load("rand_over", '{8'($urandom_range(255, 65)), 8'h00}, 0, 0);
        run_load("rand_over_hi", '{8'h00, 8'($urandom_range(255, 1))}, 0, 0);
        for (int k = 0; k < 8; k++)
            run_load($sformatf("rand%0d", k),
                     mk_stream($urandom_range(8, 0), $urandom_range(3, 0) == 0),
                     $urandom_range(3, 0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
